// File: rtl/shared_path_arbiter.sv
// rtl/shared_path_arbiter.sv - two-requester burst-limited arbiter feeding one registered output slot
// Ownership is held per requester for up to MAX_BURST transfers while the other side waits.
module shared_path_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       gnt0,
   output logic       gnt1,
   output logic [7:0] out_data,
   output logic       out_src,
   output logic       out_valid,
   input  logic       out_ready
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic [3:0] cnt_q, cnt_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_src_q, out_src_d;

   logic       slot_free;
   logic       xfer0, xfer1;
   logic       own_req, other_req, own_xfer;
   logic [3:0] cnt_inc;
   state_t     other_state;

   assign slot_free = !out_valid_q || out_ready;
   assign gnt0      = (state_q == OWN0) && slot_free;
   assign gnt1      = (state_q == OWN1) && slot_free;
   assign xfer0     = req0 && gnt0;
   assign xfer1     = req1 && gnt1;

   assign own_req     = (state_q == OWN1) ? req1 : req0;
   assign other_req   = (state_q == OWN1) ? req0 : req1;
   assign other_state = (state_q == OWN1) ? OWN0 : OWN1;
   assign own_xfer    = xfer0 || xfer1;
   assign cnt_inc     = cnt_q + 4'd1;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               state_d = last_q ? OWN0 : OWN1;
            end else if (req0) begin
               state_d = OWN0;
            end else if (req1) begin
               state_d = OWN1;
            end
         end
         default: begin
            if (!own_req) begin
               state_d = other_req ? other_state : IDLE;
            end else if (own_xfer) begin
               if (cnt_inc == BURST_LIMIT) begin
                  if (other_req) begin
                     state_d = other_state;
                  end else begin
                     cnt_d = '0;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
      endcase
      // Any entry into an owner state restarts the burst and records the new owner.
      if ((state_d != state_q) && (state_d != IDLE)) begin
         last_d = (state_d == OWN1);
         cnt_d  = '0;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (xfer0) begin
         out_valid_d = 1'b1;
         out_data_d  = data0;
         out_src_d   = 1'b0;
      end else if (xfer1) begin
         out_valid_d = 1'b1;
         out_data_d  = data1;
         out_src_d   = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_src_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shared_path_arbiter.sv
// tb/tb_shared_path_arbiter.sv - self-checking bench for shared_path_arbiter
module tb_shared_path_arbiter;

   localparam int MB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       gnt0, gnt1, out_src, out_valid;
   logic [7:0] out_data;

   int vectors = 0;
   int miscompares = 0;

   shared_path_arbiter #(.MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .gnt0(gnt0), .gnt1(gnt1),
      .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner 2 means nobody owns the path.
   int         m_owner = 2;
   int         m_cnt = 0;
   int         m_last = 1;
   logic       m_ov = 1'b0;
   logic [7:0] m_od = 8'h00;
   logic       m_os = 1'b0;
   logic       held0 = 1'b0, held1 = 1'b0;

   task take(input int who);
      m_owner = who;
      m_last  = who;
      m_cnt   = 0;
   endtask

   always @(negedge clk) begin : model
      logic [1:0] req;
      logic [7:0] dat [2];
      logic       free, eg0, eg1;
      int         tx, oth;
      if (!rst_n) begin
         m_owner = 2; m_cnt = 0; m_last = 1;
         m_ov = 1'b0; m_od = 8'h00; m_os = 1'b0;
         held0 = 1'b0; held1 = 1'b0;
         chk("rst_gnt0", gnt0, 0);
         chk("rst_gnt1", gnt1, 0);
         chk("rst_valid", out_valid, 0);
         chk("rst_data", out_data, 8'h00);
         chk("rst_src", out_src, 0);
      end else begin
         free = !m_ov || out_ready;
         eg0  = (m_owner == 0) && free;
         eg1  = (m_owner == 1) && free;
         chk("model_gnt0", gnt0, eg0);
         chk("model_gnt1", gnt1, eg1);
         chk("model_valid", out_valid, m_ov);
         chk("model_data", out_data, m_od);
         chk("model_src", out_src, m_os);
         req    = {req1, req0};
         dat[0] = data0;
         dat[1] = data1;
         held0  = req0 && !eg0;
         held1  = req1 && !eg1;
         tx = -1;
         if (m_owner != 2 && free && req[m_owner]) tx = m_owner;
         if (tx >= 0) begin
            m_ov = 1'b1; m_od = dat[tx]; m_os = tx[0];
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         if (m_owner == 2) begin
            if (req == 2'b11) take(1 - m_last);
            else if (req[0]) take(0);
            else if (req[1]) take(1);
         end else begin
            oth = 1 - m_owner;
            if (!req[m_owner]) begin
               if (req[oth]) take(oth);
               else m_owner = 2;
            end else if (tx >= 0) begin
               m_cnt++;
               if (m_cnt == MB) begin
                  if (req[oth]) take(oth);
                  else m_cnt = 0;
               end
            end
         end
      end
   end

   task step;
      @(posedge clk);
      #1;
   endtask

   task do_reset;
      step;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
      step;
      step;
      rst_n = 1'b1;
   endtask

   initial begin : stim
      logic       a0, a1;
      logic [7:0] src_pat;
      int         k;
      src_pat = 8'b1111_0000;

      // single requester
      do_reset;
      req0 = 1'b1; data0 = 8'hAB; out_ready = 1'b1;
      step;
      #2 chk("single_gnt0", gnt0, 1);
      chk("single_gnt1", gnt1, 0);
      chk("single_valid_pre", out_valid, 0);
      step;
      req0 = 1'b0;
      #2 chk("single_data", out_data, 8'hAB);
      chk("single_src", out_src, 0);
      chk("single_valid", out_valid, 1);

      // tie after reset, burst alternation
      do_reset;
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h01; data1 = 8'h05; out_ready = 1'b1;
      step;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         #2;
         a0 = gnt0 && req0;
         a1 = gnt1 && req1;
         step;
         if (a0) data0++;
         if (a1) data1++;
         #1;
         if (out_valid && k < 8) begin
            chk("tie_src", out_src, src_pat[k]);
            chk("tie_data", out_data, 8'(k + 1));
            k++;
         end
      end
      chk("tie_words", 8'(k), 8'd8);
      req0 = 1'b0; req1 = 1'b0;

      // backpressure
      do_reset;
      req0 = 1'b1; data0 = 8'h08; out_ready = 1'b1;
      step;
      #2 chk("bp_gnt_first", gnt0, 1);
      step;
      data0 = 8'h09; out_ready = 1'b0;
      #2 chk("bp_hold_data", out_data, 8'h08);
      chk("bp_hold_gnt0", gnt0, 0);
      chk("bp_hold_valid", out_valid, 1);
      step;
      #2 chk("bp_hold_data2", out_data, 8'h08);
      chk("bp_hold_gnt0_2", gnt0, 0);
      step;
      out_ready = 1'b1;
      #2 chk("bp_resume_gnt0", gnt0, 1);
      chk("bp_resume_data", out_data, 8'h08);
      step;
      req0 = 1'b0;
      #2 chk("bp_next_data", out_data, 8'h09);
      chk("bp_next_valid", out_valid, 1);
      step;
      #2 chk("bp_drain_valid", out_valid, 0);
      chk("bp_drain_data", out_data, 8'h09);

      // release handoff
      do_reset;
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'hBB; out_ready = 1'b1;
      step;
      #2 chk("ho_gnt0", gnt0, 1);
      step;
      req0 = 1'b0;
      #2 chk("ho_first", out_data, 8'h11);
      step;
      #2 chk("ho_gnt1", gnt1, 1);
      chk("ho_gnt0_off", gnt0, 0);
      step;
      req1 = 1'b0;
      #2 chk("ho_data", out_data, 8'hBB);
      chk("ho_src", out_src, 1);
      chk("ho_valid", out_valid, 1);

      // solo burst on requester 1
      do_reset;
      req1 = 1'b1; data1 = 8'h20; out_ready = 1'b1;
      step;
      for (int i = 0; i < 10; i++) begin
         #2 chk("solo_gnt1", gnt1, 1);
         step;
         if (i == 9) req1 = 1'b0;
         else data1 = 8'(8'h21 + i);
         #1;
         chk("solo_valid", out_valid, 1);
         chk("solo_src", out_src, 1);
         chk("solo_data", out_data, 8'(8'h20 + i));
      end

      // reset mid-burst
      do_reset;
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h40; data1 = 8'h50; out_ready = 1'b1;
      step; step; step;
      #1 rst_n = 1'b0;
      #1 chk("midrst_valid", out_valid, 0);
      chk("midrst_gnt0", gnt0, 0);
      chk("midrst_gnt1", gnt1, 0);
      chk("midrst_data", out_data, 8'h00);
      step;
      step;
      rst_n = 1'b1;
      step;
      #1 chk("postrst_gnt0", gnt0, 1);
      chk("postrst_gnt1", gnt1, 0);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         step;
         if (held0) req0 = ($urandom_range(7) != 0);
         else begin
            req0  = ($urandom_range(2) != 0);
            data0 = 8'($urandom);
         end
         if (held1) req1 = ($urandom_range(7) != 0);
         else begin
            req1  = ($urandom_range(2) != 0);
            data1 = 8'($urandom);
         end
         out_ready = ($urandom_range(3) != 0);
         if (n % 700 == 350) begin
            #1 rst_n = 1'b0;
            step;
            rst_n = 1'b1;
         end
      end

      req0 = 1'b0; req1 = 1'b0;
      step; step;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/shared_path_arbiter.md
SHARED_PATH_ARBITER -- requirements
Module: shared_path_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, range 1..15: the maximum number of consecutive transfers one requester may make while the other requester is waiting.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 The block SHALL have port req0  input  1  requester 0 has data0 valid and wants the path.
REQ-005 The block SHALL have port data0  input  8  requester 0 payload.
REQ-006 The block SHALL have port req1  input  1  requester 1 has data1 valid and wants the path.
REQ-007 The block SHALL have port data1  input  8  requester 1 payload.
REQ-008 The block SHALL have port gnt0  output  1  requester 0 transfer accepted this cycle when req0 is also high.
REQ-009 The block SHALL have port gnt1  output  1  requester 1 transfer accepted this cycle when req1 is also high.
REQ-010 The block SHALL have port out_data  output  8  registered payload of the shared path.
REQ-011 The block SHALL have port out_src  output  1  source of out_data (0 = requester 0, 1 = requester 1); doubles as the select to the downstream 2-way datapath.
REQ-012 The block SHALL have port out_valid  output  1  out_data/out_src hold an unconsumed word.
REQ-013 The block SHALL have port out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1.
REQ-015 The block SHALL hold a 1-bit last-owner pointer and a 4-bit burst counter.
REQ-016 The output slot SHALL be free when out_valid==0 or out_ready==1.
REQ-017 gnt_i SHALL be combinational: state==OWNi AND slot free; gnt_i SHALL never be high in IDLE, and gnt0 and gnt1 SHALL never both be high.
REQ-018 A transfer SHALL occur when req_i && gnt_i; on the next clock out_data<=data_i, out_src<=i and out_valid<=1, giving one-cycle latency.
REQ-019 When out_ready==1 in a cycle with no transfer, out_valid SHALL go to 0 on the next clock; out_data and out_src SHALL hold their values.
REQ-020 A simultaneous out_ready and transfer SHALL replace the word with no bubble, sustaining one word per cycle.
REQ-021 In IDLE, with only req_i high, the next state SHALL be OWNi.
REQ-022 In IDLE, with both requests high, the next state SHALL be OWN of the requester that is not the last-owner.
REQ-023 In IDLE, with neither request high, the FSM SHALL stay in IDLE.
REQ-024 On entering OWNi, the last-owner pointer SHALL be set to i and the burst counter SHALL be cleared to 0.
REQ-025 In OWNi, each transfer SHALL increment the burst counter.
REQ-026 In OWNi, when a transfer brings the count to MAX_BURST and req_other is high, the next state SHALL be OWNother.
REQ-027 In OWNi, when the count reaches MAX_BURST with req_other low, the FSM SHALL stay in OWNi and the counter SHALL restart at 0.
REQ-028 In OWNi with req_i low: next state SHALL be OWNother if req_other is high, else IDLE.
REQ-029 In OWNi with req_i high, the FSM SHALL never leave OWNi because of backpressure alone, whatever the value of out_ready.
REQ-030 A requester SHALL hold data_i stable while req_i is high and gnt_i is low; dropping req_i without a grant SHALL be legal and SHALL cause no transfer.

Reset
REQ-031 While rst_n==0, the state SHALL be IDLE, last-owner 1 (so requester 0 wins the first tie), burst counter 0, out_valid 0, out_data 8'h00, out_src 0, gnt0 0 and gnt1 0.
REQ-032 Reset asserted mid-transfer or mid-burst SHALL clear all registers immediately, without waiting for clk, and SHALL discard any pending word.
REQ-033 After rst_n rises, the first grant SHALL be possible one clock after a request is seen in IDLE.

Verification
REQ-034 The bench SHALL cover: single requester, req0=1 with data0=8'hAB, out_ready=1 -> OWN0 after 1 clock; gnt0 high; next clock out_data=8'hAB, out_src=0, out_valid=1.
REQ-035 The bench SHALL cover: tie after reset, req0=req1=1 from IDLE -> OWN0 first; 4 transfers from requester 0 with MAX_BURST=4; then OWN1 for 4 transfers; out_src pattern 0,0,0,0,1,1,1,1.
REQ-036 The bench SHALL cover: backpressure, out_ready=0 with one word held -> gnt0=0, out_data frozen at 8'h08; raising out_ready -> transfer resumes the same cycle with no word lost or duplicated.
REQ-037 The bench SHALL cover: release handoff, req0 drops in OWN0 while req1=1 with data1=8'hBB -> next state OWN1; next accepted word is 8'hBB with out_src=1.
REQ-038 The bench SHALL cover: solo burst, req1 only for 10 words -> stays in OWN1 throughout; 10 consecutive words out_src=1 at one word per cycle, no gaps.
REQ-039 The bench SHALL cover: reset mid-burst, rst_n=0 between clock edges during a transfer -> out_valid=0, gnt0=gnt1=0 immediately; after release, req0=req1=1 -> requester 0 is granted first.
